// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - request/response bus between the CPU control unit and alu_serial_ctrl
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;

    // control unit side: issues operations, observes completion
    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, carry, overflow
    );

    // sequencer side
    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, carry, overflow
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer around one external alu_1bit slice (optional ALU_SERIAL_SLT_EN)
module alu_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_serial_ctrl_if.slave  bus,
    output logic              slice_a,
    output logic              slice_b,
    output logic              slice_cin,
    output logic              slice_binvert,
    output logic [1:0]        slice_op,
    input  logic              slice_result,
    input  logic              slice_cout
);

`ifdef ALU_SERIAL_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    // Operand shifters hold the bits not yet presented; bit 0 of each
    // operand lives in slice_a/slice_b while its cycle runs.
    logic [WIDTH-2:0] a_sh;
    logic [WIDTH-2:0] b_sh;
    // Result bits collected so far; the MSB arrives straight from the slice.
    logic [WIDTH-2:0] res_sh;
    logic             slt_q;

    logic             accept;
    logic             arith;
    logic             ovf_now;
    logic [WIDTH-1:0] final_res;

    // Set-less-than runs a plain subtract through the slice.
    function automatic logic [1:0] map_op(input logic [2:0] o);
        if (SLT_EN && o == 3'b111) begin
            return 2'b10;
        end
        return o[1:0];
    endfunction

    // A start in DONE is taken just like one in IDLE; RUN ignores it.
    assign accept  = bus.start && (state != RUN);
    assign arith   = (slice_op == 2'b10);
    // slice_cin doubles as the carry flip-flop, so it holds the carry into the MSB on the last bit.
    assign ovf_now = slice_cin ^ slice_cout;

    // Result as it will stand after the final bit edge.
    always_comb begin
        final_res = {slice_result, res_sh};
        if (slt_q) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_now};
        end
    end

    // Sequencer FSM: latch on start, one bit per clock, publish result and flags on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
            res_sh        <= '0;
            slt_q         <= 1'b0;
            slice_a       <= 1'b0;
            slice_b       <= 1'b0;
            slice_cin     <= 1'b0;
            slice_binvert <= 1'b0;
            slice_op      <= 2'b00;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                state         <= RUN;
                bus.busy      <= 1'b1;
                bit_cnt       <= '0;
                a_sh          <= bus.a[WIDTH-1:1];
                b_sh          <= bus.b[WIDTH-1:1];
                slt_q         <= SLT_EN && (bus.op == 3'b111);
                slice_a       <= bus.a[0];
                slice_b       <= bus.b[0];
                slice_cin     <= bus.op[2];
                slice_binvert <= bus.op[2];
                slice_op      <= map_op(bus.op);
            end else if (state == RUN) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                res_sh  <= (WIDTH-1)'({slice_result, res_sh} >> 1);
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST) begin
                    state         <= DONE;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.result    <= final_res;
                    bus.zero      <= (final_res == '0);
                    bus.carry     <= arith & slice_cout;
                    bus.overflow  <= arith & ovf_now;
                    slice_a       <= 1'b0;
                    slice_b       <= 1'b0;
                    slice_cin     <= 1'b0;
                    slice_binvert <= 1'b0;
                    slice_op      <= 2'b00;
                end else begin
                    slice_a   <= a_sh[0];
                    slice_b   <= b_sh[0];
                    slice_cin <= slice_cout;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
